// File: rtl/cgra_config_loader.sv
// cgra_config_loader: serialises host config words LSB-first onto a PE config chain,
// with a config-reset pulse before loading and done once CHAIN_LEN bits are shifted.
module cgra_config_loader #(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 64,
    parameter int RST_CYC   = 2,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              cfg_reset,
    output logic              cfg_data,
    output logic              cfg_shift,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  bit_count
);
    localparam int WW = WORD_W > 1 ? $clog2(WORD_W) : 1;
    localparam int RW = RST_CYC > 1 ? $clog2(RST_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [WW-1:0]    WLAST = WW'(WORD_W - 1);
    localparam logic [RW-1:0]    RLOAD = RW'(RST_CYC - 1);

    typedef enum logic [2:0] {IDLE, RESET, FETCH, SHIFT, DONE} state_t;

    state_t            state;
    logic [WORD_W-1:0] sreg;
    logic [WW-1:0]     wcnt;
    logic [RW-1:0]     rcnt;

    // abort is the one input allowed through to an output, so a word offered
    // alongside it is never seen as accepted by the host
    assign word_ready = (state == FETCH) && !abort;
    assign cfg_reset  = state == RESET;
    assign cfg_shift  = state == SHIFT;
    assign cfg_data   = (state == SHIFT) && sreg[0];
    assign busy       = (state == RESET) || (state == FETCH) || (state == SHIFT);
    assign done       = state == DONE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            sreg      <= '0;
            wcnt      <= '0;
            rcnt      <= '0;
            bit_count <= '0;
        end else if (abort) begin
            state     <= IDLE;
            bit_count <= '0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    state     <= RESET;
                    bit_count <= '0;
                    rcnt      <= RLOAD;
                end
                RESET: begin
                    state <= rcnt == '0 ? FETCH : RESET;
                    rcnt  <= rcnt - 1'b1;
                end
                FETCH: if (word_valid) begin
                    state <= SHIFT;
                    sreg  <= word_in;
                    wcnt  <= '0;
                end
                SHIFT: begin
                    sreg      <= sreg >> 1;
                    bit_count <= bit_count + 1'b1;
                    wcnt      <= wcnt + 1'b1;
                    state     <= bit_count == LAST ? DONE : wcnt == WLAST ? FETCH : SHIFT;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cgra_config_loader.sv
// tb_cgra_config_loader: table-driven loads on three chain lengths plus abort/reset corner cases.
module tb_cgra_config_loader;
    logic        clk = 0;
    logic        reset = 1;
    logic        abort = 0;
    logic [31:0] word_in = '0;
    logic        word_valid = 0;
    logic        start_a = 0, start_b = 0, start_c = 0;
    logic        rdy_a, rst_a, data_a, shift_a, busy_a, done_a;
    logic        rdy_b, rst_b, data_b, shift_b, busy_b, done_b;
    logic        rdy_c, rst_c, data_c, shift_c, busy_c, done_c;
    logic [15:0] bc_a, bc_b, bc_c;

    int ncmp = 0;
    int nbad = 0;
    int sel = 0;
    logic [31:0] words [3];

    always #5 clk = ~clk;

    cgra_config_loader #(.WORD_W(32), .CHAIN_LEN(64), .RST_CYC(2), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .abort(abort), .word_in(word_in),
        .word_valid(word_valid), .word_ready(rdy_a), .cfg_reset(rst_a), .cfg_data(data_a),
        .cfg_shift(shift_a), .busy(busy_a), .done(done_a), .bit_count(bc_a));
    cgra_config_loader #(.WORD_W(32), .CHAIN_LEN(40), .RST_CYC(2), .CNT_W(16)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .abort(abort), .word_in(word_in),
        .word_valid(word_valid), .word_ready(rdy_b), .cfg_reset(rst_b), .cfg_data(data_b),
        .cfg_shift(shift_b), .busy(busy_b), .done(done_b), .bit_count(bc_b));
    cgra_config_loader #(.WORD_W(32), .CHAIN_LEN(1), .RST_CYC(2), .CNT_W(16)) dut_c (
        .clk(clk), .reset(reset), .start(start_c), .abort(abort), .word_in(word_in),
        .word_valid(word_valid), .word_ready(rdy_c), .cfg_reset(rst_c), .cfg_data(data_c),
        .cfg_shift(shift_c), .busy(busy_c), .done(done_c), .bit_count(bc_c));

    logic        m_rdy, m_rst, m_data, m_shift, m_busy, m_done;
    logic [15:0] m_bc;
    assign m_rdy   = sel == 0 ? rdy_a   : sel == 1 ? rdy_b   : rdy_c;
    assign m_rst   = sel == 0 ? rst_a   : sel == 1 ? rst_b   : rst_c;
    assign m_data  = sel == 0 ? data_a  : sel == 1 ? data_b  : data_c;
    assign m_shift = sel == 0 ? shift_a : sel == 1 ? shift_b : shift_c;
    assign m_busy  = sel == 0 ? busy_a  : sel == 1 ? busy_b  : busy_c;
    assign m_done  = sel == 0 ? done_a  : sel == 1 ? done_b  : done_c;
    assign m_bc    = sel == 0 ? bc_a    : sel == 1 ? bc_b    : bc_c;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] w0, w1;
        int          stall;
        bit          poke;
        int          lat;
        int          nstr;
        logic [63:0] bits;
        int          nacc;
        int          bc;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic set_start(input int s, input logic v);
        if (s == 0) start_a = v;
        else if (s == 1) start_b = v;
        else start_c = v;
    endtask

    // drives one load on instance s, acting as the host word source
    task automatic run(input int s, input int stall, input bit poke, output int lat,
                       output int nstr, output logic [63:0] bits, output int nacc,
                       output int bc, output int bad);
        int widx, t0, stalled, post;
        bit acc;
        widx = 0; t0 = -1; stalled = 0; post = 0; acc = 0;
        lat = -1; nstr = 0; bits = '0; nacc = 0; bc = -1; bad = 0;
        sel = s;
        @(negedge clk);
        set_start(s, 1);
        word_in = words[0];
        word_valid = 1;
        @(negedge clk);
        set_start(s, 0);
        for (int cyc = 0; cyc < 400 && post < 4; cyc++) begin
            if (acc) widx++;
            word_in = words[widx > 2 ? 2 : widx];
            if (m_rst && t0 < 0) t0 = cyc;
            if (m_shift) begin
                if (nstr < 64) bits[nstr] = m_data;
                nstr++;
            end else if (m_data) bad++;
            if (m_done && lat < 0) begin
                lat = cyc - t0;
                bc = int'(m_bc);
            end
            if (lat < 0 && !m_busy) bad++;
            if (lat >= 0 && m_busy) bad++;
            if (lat >= 0) post++;
            set_start(s, poke && (m_rst || (m_shift && nstr == 20)));
            if (stall > 0 && widx == 1 && m_rdy && stalled < stall) begin
                word_valid = 0;
                stalled++;
                if (m_shift) bad++;
            end else word_valid = 1;
            acc = word_valid && m_rdy;
            if (acc) nacc++;
            @(negedge clk);
        end
        set_start(s, 0);
    endtask

    task automatic apply(input vec_t v, input string tag);
        int lat, nstr, nacc, bc, bad;
        logic [63:0] bits;
        words[0] = v.w0;
        words[1] = v.w1;
        words[2] = 32'hDEAD_BEEF;
        run(v.sel, v.stall, v.poke, lat, nstr, bits, nacc, bc, bad);
        chk({tag, "_lat"},  64'(lat),  64'(v.lat));
        chk({tag, "_nstr"}, 64'(nstr), 64'(v.nstr));
        chk({tag, "_bits"}, bits,      v.bits);
        chk({tag, "_nacc"}, 64'(nacc), 64'(v.nacc));
        chk({tag, "_bc"},   64'(bc),   64'(v.bc));
        chk({tag, "_bad"},  64'(bad),  64'd0);
    endtask

    initial begin
        int k;
        vecs[0] = '{"base64",  0, 32'h8000_0001, 32'h0000_0003, 0, 0, 68, 64, 64'h0000_0003_8000_0001, 2, 64};
        vecs[1] = '{"mixed64", 0, 32'h1234_5678, 32'hCAFE_F00D, 0, 0, 68, 64, 64'hCAFE_F00D_1234_5678, 2, 64};
        vecs[2] = '{"part40",  1, 32'hFFFF_FFFF, 32'h0000_01A5, 0, 0, 44, 40, 64'h0000_00A5_FFFF_FFFF, 2, 40};
        vecs[3] = '{"stall64", 0, 32'h8000_0001, 32'h0000_0003, 5, 0, 73, 64, 64'h0000_0003_8000_0001, 2, 64};
        vecs[4] = '{"poke64",  0, 32'h0F0F_0F0F, 32'hA5A5_A5A5, 0, 1, 68, 64, 64'hA5A5_A5A5_0F0F_0F0F, 2, 64};
        vecs[5] = '{"chain1",  2, 32'h0000_0001, 32'hFFFF_FFFF, 0, 0, 4,  1,  64'h1, 1, 1};
        vecs[6] = '{"chain1z", 2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0, 0, 4,  1,  64'h0, 1, 1};

        #2;
        chk("rst_outs", {58'd0, rdy_a, rst_a, data_a, shift_a, busy_a, done_a}, 64'd0);
        chk("rst_bc", 64'(bc_a), 64'd0);
        #11 reset = 0;
        @(negedge clk);
        chk("idle_outs", {58'd0, rdy_a, rst_a, data_a, shift_a, busy_a, done_a}, 64'd0);

        foreach (vecs[i]) apply(vecs[i], vecs[i].name);

        // abort on the 10th SHIFT cycle
        sel = 0;
        @(negedge clk);
        start_a = 1; word_valid = 1; word_in = 32'h8000_0001;
        @(negedge clk);
        start_a = 0;
        k = 0;
        for (int i = 0; i < 200 && k < 10; i++) begin
            if (shift_a) k++;
            if (k < 10) @(negedge clk);
        end
        chk("abort_reach", 64'(k), 64'd10);
        abort = 1;
        @(negedge clk);
        chk("abort_outs", {60'd0, shift_a, busy_a, rdy_a, done_a}, 64'd0);
        chk("abort_bc", 64'(bc_a), 64'd0);
        abort = 0;
        apply(vecs[0], "reload_abort");

        // abort while FETCH is offered a word
        @(negedge clk);
        start_a = 1;
        @(negedge clk);
        start_a = 0;
        k = 0;
        for (int i = 0; i < 20 && !rdy_a; i++) @(negedge clk);
        chk("fetch_reach", 64'(rdy_a), 64'd1);
        abort = 1; word_valid = 1;
        #1;
        chk("abort_rdy", 64'(rdy_a), 64'd0);
        @(negedge clk);
        chk("abort_fetch", {61'd0, busy_a, shift_a, bc_a != 0}, 64'd0);
        abort = 0;

        // asynchronous reset mid-SHIFT
        @(negedge clk);
        start_a = 1;
        @(negedge clk);
        start_a = 0;
        k = 0;
        for (int i = 0; i < 200 && k < 5; i++) begin
            if (shift_a) k++;
            if (k < 5) @(negedge clk);
        end
        chk("areset_reach", 64'(bc_a), 64'd4);
        #3 reset = 1;
        #1;
        chk("areset_outs", {58'd0, rdy_a, rst_a, data_a, shift_a, busy_a, done_a}, 64'd0);
        chk("areset_bc", 64'(bc_a), 64'd0);
        #3 reset = 0;
        @(negedge clk);
        chk("areset_idle", {58'd0, rdy_a, rst_a, data_a, shift_a, busy_a, done_a}, 64'd0);
        apply(vecs[0], "reload_reset");

        // restart from DONE on the one-bit chain
        apply(vecs[5], "chain1_again");
        sel = 2;
        chk("c_done", 64'(done_c), 64'd1);
        start_c = 1;
        @(negedge clk);
        start_c = 0;
        chk("c_restart", {60'd0, rst_c, busy_c, done_c, bc_c != 0}, 64'b1100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end
endmodule
